eth_ctrl_frame_gen: RTL and testbench

ETH_CTRL_FRAME_GEN -- requirements
Module: eth_ctrl_frame_gen

---
 rtl/eth_ctrl_frame_gen_pkg.sv | 50 +++++
 rtl/eth_ctrl_frame_gen.sv | 138 +++++++++++++
 tb/tb_eth_ctrl_frame_gen.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_ctrl_frame_gen_pkg.sv
// Shared definitions for the control-frame generator: frame constants,
// FSM encoding, registered request record and the beat-to-tdata mux.
package eth_ctrl_frame_gen_pkg;

  localparam logic [15:0] ETH_CTRL_ETHERTYPE = 16'h88B5;
  localparam int unsigned CTRL_FRAME_BEATS   = 8;
  localparam logic [15:0] CTRL_FRAME_BYTES   = 16'd60;
  localparam logic [7:0]  CTRL_LAST_KEEP     = 8'h0F;
  localparam logic [7:0]  CTRL_FULL_KEEP     = 8'hFF;
  localparam logic [2:0]  HDR_LAST_BEAT      = 3'd2;
  localparam logic [2:0]  PAD_LAST_BEAT      = 3'(CTRL_FRAME_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAD  = 2'd2,
    ST_GAP  = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [7:0]  mtype;
    logic [15:0] seq;
    logic [31:0] param;
  } ctrl_req_t;

  // Network-order word (first byte in the MSBs) to lane order (first byte on [7:0]).
  function automatic logic [63:0] bswap64(input logic [63:0] be);
    logic [63:0] le;
    le = 64'h0;
    for (int i = 0; i < 8; i++) begin
      le[8*i +: 8] = be[56-8*i +: 8];
    end
    return le;
  endfunction

  function automatic logic [63:0] beat_data(input logic [2:0] beat, input ctrl_req_t f,
                                            input logic [15:0] etype);
    logic [63:0] d;
    case (beat)
      3'd0:    d = bswap64({f.dst, f.src[47:32]});
      3'd1:    d = bswap64({f.src[31:0], etype, f.mtype, 8'h00});
      3'd2:    d = bswap64({f.seq, f.param, CTRL_FRAME_BYTES});
      default: d = 64'h0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/eth_ctrl_frame_gen.sv
// Emits fixed-format 60-byte Ethernet control frames (8 x 64-bit beats) on an
// un-backpressured stream, with a programmable idle gap between frames.
module eth_ctrl_frame_gen
  import eth_ctrl_frame_gen_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE  = ETH_CTRL_ETHERTYPE,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        i_crtl_clk,
  input  logic        i_crtl_rst,
  input  logic        i_enable,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [7:0]  i_req_type,
  input  logic [15:0] i_req_seq,
  input  logic [31:0] i_req_param,
  input  logic [47:0] i_dst_mac,
  input  logic [47:0] i_src_mac,
  output logic        m_ctrl_axis_tvalid,
  output logic [63:0] m_ctrl_axis_tdata,
  output logic        m_ctrl_axis_tlast,
  output logic [7:0]  m_ctrl_axis_tkeep,
  output logic        m_ctrl_axis_tuser,
  output logic [31:0] o_frame_cnt,
  output logic        o_busy
);

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  ctrl_state_e r_state, w_state_nxt;
  logic [2:0]  r_beat, w_beat_nxt;
  logic [7:0]  r_gap, w_gap_nxt;
  ctrl_req_t   r_req, w_req_nxt;
  logic        r_rst_done;
  logic        w_accept;
  logic        w_emit;
  logic        w_last;
  logic        r_tvalid;
  logic [63:0] r_tdata;
  logic        r_tlast;
  logic [7:0]  r_tkeep;
  logic [31:0] r_frame_cnt;

  // Ready only after the first edge out of reset, so it cannot rise asynchronously.
  assign o_req_ready = (r_state == ST_IDLE) && i_enable && r_rst_done;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_req_nxt   = w_accept ? '{dst: i_dst_mac, src: i_src_mac, mtype: i_req_type,
                                    seq: i_req_seq, param: i_req_param} : r_req;

  // Next-state, beat and gap counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_gap_nxt   = r_gap;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_HDR;
          w_beat_nxt  = 3'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HDR: begin
        w_beat_nxt = r_beat + 3'd1;
        if (r_beat == HDR_LAST_BEAT) begin
          w_state_nxt = ST_PAD;
        end else begin
          w_state_nxt = ST_HDR;
        end
      end
      ST_PAD: begin
        if (r_beat == PAD_LAST_BEAT) begin
          w_state_nxt = ST_GAP;
          w_beat_nxt  = 3'd0;
          w_gap_nxt   = 8'd0;
        end else begin
          w_beat_nxt = r_beat + 3'd1;
        end
      end
      ST_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_gap_nxt   = 8'd0;
        end else begin
          w_gap_nxt = r_gap + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_beat_nxt  = 3'd0;
        w_gap_nxt   = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so beat 0 follows acceptance by one cycle.
  assign w_emit = (w_state_nxt == ST_HDR) || (w_state_nxt == ST_PAD);
  assign w_last = w_emit && (w_beat_nxt == PAD_LAST_BEAT);

  // State, captured request and registered stream outputs.
  always_ff @(posedge i_crtl_clk or posedge i_crtl_rst) begin
    if (i_crtl_rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= 3'd0;
      r_gap       <= 8'd0;
      r_req       <= '0;
      r_rst_done  <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tdata     <= 64'h0;
      r_tlast     <= 1'b0;
      r_tkeep     <= 8'h00;
      r_frame_cnt <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat     <= w_beat_nxt;
      r_gap      <= w_gap_nxt;
      r_req      <= w_req_nxt;
      r_rst_done <= 1'b1;
      r_tvalid   <= w_emit;
      r_tdata    <= w_emit ? beat_data(w_beat_nxt, w_req_nxt, ETHERTYPE) : 64'h0;
      r_tlast    <= w_last;
      r_tkeep    <= w_emit ? (w_last ? CTRL_LAST_KEEP : CTRL_FULL_KEEP) : 8'h00;
      if (w_last) begin
        r_frame_cnt <= r_frame_cnt + 32'd1;
      end
    end
  end

  assign m_ctrl_axis_tvalid = r_tvalid;
  assign m_ctrl_axis_tdata  = r_tdata;
  assign m_ctrl_axis_tlast  = r_tlast;
  assign m_ctrl_axis_tkeep  = r_tkeep;
  assign m_ctrl_axis_tuser  = 1'b0;
  assign o_frame_cnt        = r_frame_cnt;
  assign o_busy             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_eth_ctrl_frame_gen.sv
// Scoreboard bench for eth_ctrl_frame_gen: stimulus queues expected beats,
// a negedge monitor pops and compares every beat the DUT emits.
module tb_eth_ctrl_frame_gen;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_type;
  logic [15:0] req_seq;
  logic [31:0] req_param;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic        tvalid;
  logic [63:0] tdata;
  logic        tlast;
  logic [7:0]  tkeep;
  logic        tuser;
  logic [31:0] frame_cnt;
  logic        busy;

  beat_t sb[$];
  int    starts[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  eth_ctrl_frame_gen #(.ETHERTYPE(16'h88B5), .GAP_CYCLES(4)) dut (
    .i_crtl_clk(clk), .i_crtl_rst(rst), .i_enable(en),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_type(req_type), .i_req_seq(req_seq), .i_req_param(req_param),
    .i_dst_mac(dst_mac), .i_src_mac(src_mac),
    .m_ctrl_axis_tvalid(tvalid), .m_ctrl_axis_tdata(tdata),
    .m_ctrl_axis_tlast(tlast), .m_ctrl_axis_tkeep(tkeep),
    .m_ctrl_axis_tuser(tuser), .o_frame_cnt(frame_cnt), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Independent byte-level frame builder: returns {beat2, beat1, beat0}.
  function automatic logic [191:0] model(input logic [47:0] d, input logic [47:0] s,
                                         input logic [7:0] t, input logic [15:0] q,
                                         input logic [31:0] p);
    logic [7:0]   by [24];
    logic [191:0] r;
    for (int i = 0; i < 6; i++) begin
      by[i]     = d[40-8*i +: 8];
      by[6 + i] = s[40-8*i +: 8];
    end
    by[12] = 8'h88; by[13] = 8'hB5; by[14] = t; by[15] = 8'h00;
    by[16] = q[15:8]; by[17] = q[7:0];
    for (int i = 0; i < 4; i++) by[18 + i] = p[24-8*i +: 8];
    by[22] = 8'h00; by[23] = 8'd60;
    r = '0;
    for (int k = 0; k < 24; k++) r[8*k +: 8] = by[k];
    return r;
  endfunction

  task automatic push_frame(input logic [191:0] hdr);
    beat_t b;
    for (int k = 0; k < 8; k++) begin
      b.data = (k < 3) ? hdr[64*k +: 64] : 64'h0;
      b.keep = (k == 7) ? 8'h0F : 8'hFF;
      b.last = (k == 7);
      sb.push_back(b);
    end
  endtask

  task automatic drive(input logic [47:0] d, input logic [47:0] s, input logic [7:0] t,
                       input logic [15:0] q, input logic [31:0] p);
    dst_mac = d; src_mac = s; req_type = t; req_seq = q; req_param = p;
  endtask

  // Waits (bounded) for the handshake, queues the expected frame, returns 1ns after the edge.
  task automatic wait_accept(input string name, input logic [191:0] hdr, output int waited);
    bit got = 1'b0;
    waited = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      waited++;
      if (req_valid && req_ready) got = 1'b1;
    end
    chk({name, "_accept"}, {63'h0, got}, 64'h1);
    if (got) push_frame(hdr);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !busy && !tvalid) done = 1'b1;
    end
    chk({name, "_drain"}, {63'h0, done}, 64'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every beat is popped from the scoreboard; idle cycles must be all zero.
  initial begin
    beat_t e;
    logic  prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tvalid) begin
        if (!prev_valid) starts.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_beat", {63'h0, tvalid}, 64'h0);
        end else begin
          e = sb.pop_front();
          chk("beat_tdata", tdata, e.data);
          chk("beat_tkeep", {56'h0, tkeep}, {56'h0, e.keep});
          chk("beat_tlast", {63'h0, tlast}, {63'h0, e.last});
          chk("beat_tuser", {63'h0, tuser}, 64'h0);
        end
      end else begin
        chk("idle_zero", {tdata, tkeep, tlast, tuser} == 74'h0 ? 64'h1 : 64'h0, 64'h1);
      end
      prev_valid = tvalid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int           w;
    logic [191:0] exp_c;
    rst = 1'b1; en = 1'b1; req_valid = 1'b0;
    drive(48'h0, 48'h0, 8'h0, 16'h0, 32'h0);
    #2;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", {63'h0, tvalid}, 64'h0);
    chk("rst_tkeep_tlast", {55'h0, tkeep, tlast}, 64'h0);
    chk("rst_ready", {63'h0, req_ready}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_cnt", {32'h0, frame_cnt}, 64'h0);
    rst = 1'b0;
    #1;
    chk("ready_before_edge", {63'h0, req_ready}, 64'h0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", {63'h0, req_ready}, 64'h1);

    // Directed frame with hand-computed beats.
    drive(48'h001122334455, 48'hAABBCCDDEEFF, 8'h01, 16'h1234, 32'hDEADBEEF);
    req_valid = 1'b1;
    wait_accept("t1", {64'h3C00EFBEADDE3412, 64'h0001B588FFEEDDCC, 64'hBBAA554433221100}, w);
    req_valid = 1'b0;
    chk("t1_latency", {63'h0, tvalid}, 64'h1);
    chk("t1_busy", {63'h0, busy}, 64'h1);
    wait_drain("t1");
    chk("t1_cnt", {32'h0, frame_cnt}, 64'h1);

    // Valid held high: three frames, beat-0 starts 13 cycles apart.
    pulse_reset();
    starts.delete();
    drive(48'h0A0B0C0D0E0F, 48'h102030405060, 8'h7E, 16'hBEEF, 32'h01234567);
    req_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_accept("t2", model(48'h0A0B0C0D0E0F, 48'h102030405060, 8'h7E, 16'hBEEF, 32'h01234567), w);
    end
    req_valid = 1'b0;
    wait_drain("t2");
    chk("t2_nframes", starts.size(), 64'd3);
    if (starts.size() == 3) begin
      chk("t2_spacing01", starts[1] - starts[0], 64'd13);
      chk("t2_spacing12", starts[2] - starts[1], 64'd13);
    end
    chk("t2_cnt", {32'h0, frame_cnt}, 64'd3);

    // Enable dropped at beat 3: frame completes, nothing accepted while low.
    drive(48'h112233445566, 48'h778899AABBCC, 8'h22, 16'h0001, 32'hCAFEF00D);
    req_valid = 1'b1;
    wait_accept("t3a", model(48'h112233445566, 48'h778899AABBCC, 8'h22, 16'h0001, 32'hCAFEF00D), w);
    drive(48'hFEDCBA987654, 48'h0102030405AB, 8'h33, 16'h0002, 32'h0BADC0DE);
    exp_c = model(48'hFEDCBA987654, 48'h0102030405AB, 8'h33, 16'h0002, 32'h0BADC0DE);
    repeat (3) @(posedge clk);
    #1;
    en = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("t3_ready_low", {63'h0, req_ready}, 64'h0);
    end
    chk("t3_idle", {63'h0, busy}, 64'h0);
    @(posedge clk);
    #1;
    en = 1'b1;
    wait_accept("t3b", exp_c, w);
    chk("t3_resume_cycles", w, 64'd1);
    req_valid = 1'b0;
    wait_drain("t3");
    chk("t3_cnt", {32'h0, frame_cnt}, 64'd5);

    // Inputs scrambled every cycle after acceptance must not leak into the frame.
    drive(48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 8'h44, 16'hFFFF, 32'h80000001);
    req_valid = 1'b1;
    wait_accept("t5", model(48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 8'h44, 16'hFFFF, 32'h80000001), w);
    req_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive({$urandom, $urandom} , {$urandom, $urandom}, 8'($urandom), 16'($urandom), $urandom);
      @(posedge clk);
      #1;
    end
    wait_drain("t5");
    chk("t5_cnt", {32'h0, frame_cnt}, 64'd6);

    // Reset at beat 5 truncates the frame; the next frame is complete.
    drive(48'h010101010101, 48'h020202020202, 8'h55, 16'h0A0A, 32'h13579BDF);
    req_valid = 1'b1;
    wait_accept("t4a", model(48'h010101010101, 48'h020202020202, 8'h55, 16'h0A0A, 32'h13579BDF), w);
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t4_pre_valid", {63'h0, tvalid}, 64'h1);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("t4_tvalid", {63'h0, tvalid}, 64'h0);
    chk("t4_tlast", {63'h0, tlast}, 64'h0);
    chk("t4_cnt", {32'h0, frame_cnt}, 64'h0);
    chk("t4_busy", {63'h0, busy}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 8'h66, 16'h4242, 32'h00FF00FF);
    req_valid = 1'b1;
    wait_accept("t4b", model(48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 8'h66, 16'h4242, 32'h00FF00FF), w);
    req_valid = 1'b0;
    wait_drain("t4");
    chk("t4_cnt_after", {32'h0, frame_cnt}, 64'd1);

    // Frame counter wrap.
    force dut.r_frame_cnt = 32'hFFFFFFFF;
    #1;
    release dut.r_frame_cnt;
    #1;
    chk("t6_preset", {32'h0, frame_cnt}, 64'hFFFFFFFF);
    drive(48'h0000000000AA, 48'h0000000000BB, 8'h77, 16'h0003, 32'h00000000);
    req_valid = 1'b1;
    wait_accept("t6", model(48'h0000000000AA, 48'h0000000000BB, 8'h77, 16'h0003, 32'h00000000), w);
    req_valid = 1'b0;
    wait_drain("t6");
    chk("t6_wrap", {32'h0, frame_cnt}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
